lanectrl_pause_gen: RTL
=======================

LANECTRL_PAUSE_GEN -- requirements
Module: lanectrl_pause_gen

Interface
REQ-001 Parameter PRE_CYCLES, default 2, idle-guard cycles (pause low, BUSY high) before pause; range 0..15.
REQ-002 Parameter PAUSE_CYCLES, default 4, cycles HS_IO_CLK_PAUSE held high; range 1..15.
REQ-003 Parameter POST_CYCLES, default 2, guard cycles after pause before acknowledge; range 0..15.
REQ-004 Parameter MIN_GAP, default 8, cycles after acknowledge before a new request is accepted; range 0..255.
REQ-005 CLK  input  1  lane control clock; all state on rising edge; one clock; reset is asynchronous and active-high.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 UPDATE_REQ  input  1  level request for a delay-code update; held high until UPDATE_ACK.
REQ-008 UPDATE_ACK  output  1  one-cycle pulse: update sequence complete.
REQ-009 HS_IO_CLK_PAUSE  output  1  registered pause request to the downstream pause synchronizer.
REQ-010 DELAY_LOAD  output  1  one-cycle strobe loading the new delay code while paused.
REQ-011 BUSY  output  1  high in every state except IDLE.
REQ-012 PAUSE_COUNT  output  8  completed sequences, saturating.

Function
REQ-013 The FSM SHALL have states IDLE, PRE, PAUSE, POST, ACK and GAP.
REQ-014 All outputs SHALL be registered; none depends combinationally on UPDATE_REQ.
REQ-015 IDLE with UPDATE_REQ=1 at edge of cycle 0 SHALL enter PRE (or PAUSE if PRE_CYCLES=0) in cycle 1.
REQ-016 PRE SHALL last exactly PRE_CYCLES cycles, HS_IO_CLK_PAUSE=0, BUSY=1.
REQ-017 PAUSE SHALL last exactly PAUSE_CYCLES cycles with HS_IO_CLK_PAUSE=1 in each; no glitch or gap.
REQ-018 DELAY_LOAD SHALL be high for exactly one cycle: PAUSE cycle index floor(PAUSE_CYCLES/2), 0-based.
REQ-019 POST SHALL last exactly POST_CYCLES cycles, HS_IO_CLK_PAUSE=0; skipped when POST_CYCLES=0.
REQ-020 ACK SHALL last one cycle with UPDATE_ACK=1; PAUSE_COUNT increments in that cycle, saturating at 255.
REQ-021 GAP SHALL last MIN_GAP cycles, BUSY=1, requests ignored; with MIN_GAP=0 ACK goes directly to IDLE.
REQ-022 Defaults, request at cycle 0: PRE 1-2, PAUSE 3-6, DELAY_LOAD 5, POST 7-8, UPDATE_ACK 9, GAP 10-17, IDLE 18.
REQ-023 UPDATE_REQ dropping mid-sequence SHALL NOT abort; sequence completes and UPDATE_ACK still issues.
REQ-024 UPDATE_REQ still high on return to IDLE SHALL be a new request, starting the next sequence that cycle.
REQ-025 Phase timing SHALL use one 4-bit down-counter reloaded on each state entry; the GAP count uses 8 bits.

Reset
REQ-026 RESET=1 SHALL force, asynchronously, state IDLE, counters 0, PAUSE_COUNT=0 and all outputs 0.
REQ-027 Reset mid-sequence (incl. during PAUSE) SHALL drop HS_IO_CLK_PAUSE immediately; no UPDATE_ACK is produced.
REQ-028 After RESET deasserts, first request sampled on the first rising edge SHALL follow REQ-015 timing.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the 4-bit phase and 8-bit gap counter widths, and parameter-range constants.
REQ-030 One sub-module, lanectrl_pause_timer (loadable down-counter with zero flag), is natural; the FSM remains in lanectrl_pause_gen.
REQ-031 Out-of-range parameters SHALL be flagged at elaboration.

Verification
REQ-032 Defaults, UPDATE_REQ high cycle 0 until ACK -> pause high 3-6, DELAY_LOAD 5 only, UPDATE_ACK 9, BUSY 1-17, PAUSE_COUNT=1.
REQ-033 PRE_CYCLES=0, POST_CYCLES=0, MIN_GAP=0, PAUSE_CYCLES=1 -> pause cycle 1, DELAY_LOAD 1, UPDATE_ACK 2, IDLE 3.
REQ-034 Defaults, UPDATE_REQ held high continuously -> sequences restart at cycles 0, 18, 36; UPDATE_ACK 9, 27, 45.
REQ-035 Defaults, RESET pulsed at cycle 4 -> HS_IO_CLK_PAUSE low asynchronously, no DELAY_LOAD/UPDATE_ACK, PAUSE_COUNT=0.
REQ-036 Defaults, UPDATE_REQ pulsed only cycle 0 -> full sequence, UPDATE_ACK at 9; 300 back-to-back sequences -> PAUSE_COUNT=255.

Source files
------------

// File: rtl/lanectrl_pause_gen_pkg.sv
// lanectrl_pause_gen_pkg: shared FSM states, counter widths and parameter limits for the pause generator
package lanectrl_pause_gen_pkg;
  typedef enum logic [2:0] {IDLE, PRE, PAUSE, POST, ACK, GAP} state_e;
  localparam int PH_W = 4;
  localparam int GAP_W = 8;
  localparam int PRE_MAX = 15;
  localparam int PAUSE_MIN = 1;
  localparam int PAUSE_MAX = 15;
  localparam int POST_MAX = 15;
  localparam int GAP_MAX = 255;
endpackage

// File: rtl/lanectrl_pause_timer.sv
// lanectrl_pause_timer: loadable down-counter that stops at zero (clk, rst, load, load_val -> cnt)
module lanectrl_pause_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
endmodule

// File: rtl/lanectrl_pause_gen.sv
// lanectrl_pause_gen: UPDATE_REQ -> PRE/PAUSE/POST/ACK/GAP sequence driving HS_IO_CLK_PAUSE, DELAY_LOAD, UPDATE_ACK, BUSY, PAUSE_COUNT
module lanectrl_pause_gen
  import lanectrl_pause_gen_pkg::*;
#(
  parameter int PRE_CYCLES   = 2,
  parameter int PAUSE_CYCLES = 4,
  parameter int POST_CYCLES  = 2,
  parameter int MIN_GAP      = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UPDATE_REQ,
  output logic       UPDATE_ACK,
  output logic       HS_IO_CLK_PAUSE,
  output logic       DELAY_LOAD,
  output logic       BUSY,
  output logic [7:0] PAUSE_COUNT
);
  if (PRE_CYCLES < 0 || PRE_CYCLES > PRE_MAX) begin : g_bad_pre
    $error("PRE_CYCLES out of range");
  end
  if (PAUSE_CYCLES < PAUSE_MIN || PAUSE_CYCLES > PAUSE_MAX) begin : g_bad_pause
    $error("PAUSE_CYCLES out of range");
  end
  if (POST_CYCLES < 0 || POST_CYCLES > POST_MAX) begin : g_bad_post
    $error("POST_CYCLES out of range");
  end
  if (MIN_GAP < 0 || MIN_GAP > GAP_MAX) begin : g_bad_gap
    $error("MIN_GAP out of range");
  end
  localparam logic [PH_W-1:0] PRE_LD = PH_W'(PRE_CYCLES - 1);
  localparam logic [PH_W-1:0] PAUSE_LD = PH_W'(PAUSE_CYCLES - 1);
  localparam logic [PH_W-1:0] POST_LD = PH_W'(POST_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(MIN_GAP - 1);
  // the phase counter counts down from PAUSE_CYCLES-1, so the mid pause index maps to this count
  localparam logic [PH_W-1:0] DL_CNT = PH_W'(PAUSE_CYCLES - 1 - PAUSE_CYCLES / 2);
  localparam state_e AFTER_IDLE = (PRE_CYCLES == 0) ? PAUSE : PRE;
  localparam state_e AFTER_PAUSE = (POST_CYCLES == 0) ? ACK : POST;
  localparam state_e AFTER_ACK = (MIN_GAP == 0) ? IDLE : GAP;
  state_e state_d, state_q;
  logic [PH_W-1:0] ph_cnt, ph_val, ph_next;
  logic [GAP_W-1:0] gap_cnt;
  logic ph_load, gap_load, entering;
  logic pause_d, pause_q, load_d, load_q, ack_d, ack_q, busy_d, busy_q;
  logic [7:0] count_d, count_q;
  lanectrl_pause_timer #(.W(PH_W)) u_ph (
    .clk(CLK), .rst(RESET), .load(ph_load), .load_val(ph_val), .cnt(ph_cnt)
  );
  lanectrl_pause_timer #(.W(GAP_W)) u_gap (
    .clk(CLK), .rst(RESET), .load(gap_load), .load_val(GAP_LD), .cnt(gap_cnt)
  );
  // outputs are registered from the next-state decode so they line up with the state they describe
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = UPDATE_REQ ? AFTER_IDLE : IDLE;
      PRE:     state_d = ph_cnt == '0 ? PAUSE : PRE;
      PAUSE:   state_d = ph_cnt == '0 ? AFTER_PAUSE : PAUSE;
      POST:    state_d = ph_cnt == '0 ? ACK : POST;
      ACK:     state_d = AFTER_ACK;
      GAP:     state_d = gap_cnt == '0 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    entering = state_d != state_q;
    ph_load = entering && (state_d inside {PRE, PAUSE, POST});
    ph_val = state_d == PRE ? PRE_LD : state_d == PAUSE ? PAUSE_LD : POST_LD;
    ph_next = ph_load ? ph_val : ph_cnt - PH_W'(1);
    gap_load = entering && state_d == GAP;
    pause_d = state_d == PAUSE;
    load_d = pause_d && ph_next == DL_CNT;
    ack_d = state_d == ACK;
    busy_d = state_d != IDLE;
    count_d = (ack_d && count_q != 8'hFF) ? count_q + 8'd1 : count_q;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pause_q <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end
  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_LOAD = load_q;
  assign UPDATE_ACK = ack_q;
  assign BUSY = busy_q;
  assign PAUSE_COUNT = count_q;
endmodule
